// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline-stage registers.
// Stage widths below are the defaults for each boundary of the 5-stage core.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int CTRL_MEMTOREG = 0;
  localparam int CTRL_REGWRITE = 1;

  localparam int IFID_DATA_W   = 64;
  localparam int IFID_CTRL_W   = 1;
  localparam int IDEX_DATA_W   = 106;
  localparam int IDEX_CTRL_W   = 8;
  localparam int EXMEM_DATA_W  = 69;
  localparam int EXMEM_CTRL_W  = 4;
  localparam int MEMWB_DATA_W  = 69;
  localparam int MEMWB_CTRL_W  = 2;
  localparam int BUBBLE_CNT_W  = 16;

  // Occupancy is fully described by the two valid flags.
  function automatic pipe_state_e stage_state(input logic main_vld, input logic skid_vld);
    if (!main_vld)     return ST_EMPTY;
    else if (!skid_vld) return ST_ONE;
    else               return ST_FULL;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance monitoring; holds at all-ones, cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with one-entry skid buffer; 1-cycle latency, full throughput.
// inReady comes straight from the skid flag, so no combinational path from outReady.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inData,
  input  logic [CTRL_W-1:0] inCtrl,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic [CTRL_W-1:0] outCtrl,
  output logic [CNT_W-1:0]  bubbleCount
);

  logic              mainValid_q, mainValid_d;
  logic [DATA_W-1:0] mainData_q,  mainData_d;
  logic [CTRL_W-1:0] mainCtrl_q,  mainCtrl_d;
  logic              skidValid_q, skidValid_d;
  logic [DATA_W-1:0] skidData_q,  skidData_d;
  logic [CTRL_W-1:0] skidCtrl_q,  skidCtrl_d;

  pipe_state_e state_w;
  logic        acceptIn;
  logic        acceptOut;

  assign state_w   = stage_state(mainValid_q, skidValid_q);
  assign inReady   = !skidValid_q;
  assign outValid  = mainValid_q;
  assign outData   = mainData_q;
  assign outCtrl   = mainValid_q ? mainCtrl_q : '0;
  assign acceptIn  = inValid & inReady;
  assign acceptOut = mainValid_q & outReady;

  always_comb begin
    mainValid_d = mainValid_q;
    mainData_d  = mainData_q;
    mainCtrl_d  = mainCtrl_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    skidCtrl_d  = skidCtrl_q;
    if (flush) begin
      // Data registers keep stale contents; the valid gating hides them.
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else begin
      case (state_w)
        ST_EMPTY: begin
          if (acceptIn) begin
            mainValid_d = 1'b1;
            mainData_d  = inData;
            mainCtrl_d  = inCtrl;
          end
        end
        ST_ONE: begin
          if (acceptIn && acceptOut) begin
            mainData_d = inData;
            mainCtrl_d = inCtrl;
          end else if (acceptIn) begin
            skidValid_d = 1'b1;
            skidData_d  = inData;
            skidCtrl_d  = inCtrl;
          end else if (acceptOut) begin
            mainValid_d = 1'b0;
          end
        end
        default: begin
          if (acceptOut) begin
            mainData_d  = skidData_q;
            mainCtrl_d  = skidCtrl_q;
            skidValid_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      mainValid_q <= 1'b0;
      mainData_q  <= '0;
      mainCtrl_q  <= '0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      skidCtrl_q  <= '0;
    end else begin
      mainValid_q <= mainValid_d;
      mainData_q  <= mainData_d;
      mainCtrl_q  <= mainCtrl_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      skidCtrl_q  <= skidCtrl_d;
    end
  end

  always_ff @(posedge clock) begin
    if (resetN) assert (!skidValid_q || mainValid_q);
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clock  (clock),
    .resetN (resetN),
    .inc    (!mainValid_q && outReady),
    .count  (bubbleCount)
  );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: reset, streaming, back-pressure, flush, bubble count, saturation.
module tb_pipe_stage_hs;
  import pipe_pkg::*;

  localparam int DW = 69;
  localparam int CW = 2;

  logic          clock;
  logic          resetN;
  logic          flush;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inData;
  logic [CW-1:0] inCtrl;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] outData;
  logic [CW-1:0] outCtrl;
  logic [15:0]   bubbleCount;

  logic          s_inReady;
  logic          s_outValid;
  logic          s_outReady;
  logic [DW-1:0] s_outData;
  logic [CW-1:0] s_outCtrl;
  logic [2:0]    s_bubbleCount;

  int chk_cnt = 0;
  int err_cnt = 0;

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clock(clock), .resetN(resetN), .flush(flush),
    .inValid(inValid), .inReady(inReady), .inData(inData), .inCtrl(inCtrl),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outCtrl(outCtrl),
    .bubbleCount(bubbleCount)
  );

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(3)) dut_sat (
    .clock(clock), .resetN(resetN), .flush(1'b0),
    .inValid(1'b0), .inReady(s_inReady), .inData('0), .inCtrl('0),
    .outValid(s_outValid), .outReady(s_outReady), .outData(s_outData), .outCtrl(s_outCtrl),
    .bubbleCount(s_bubbleCount)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    resetN = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0; inCtrl = '0;
    outReady = 1'b0; s_outReady = 1'b0;
    #3 resetN = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    step();

    // Mid-run reset with a handshake offered: must be ignored.
    inValid = 1'b1; inData = 69'h0ABC; inCtrl = 2'b10; outReady = 1'b1;
    resetN = 1'b0;
    #1;
    check("rst_outValid", outValid, 0);
    check("rst_outCtrl",  outCtrl,  0);
    check("rst_outData",  outData,  0);
    check("rst_inReady",  inReady,  1);
    check("rst_bubble",   bubbleCount, 0);
    step();
    check("rst_hold_outValid", outValid, 0);
    check("rst_hold_inReady",  inReady,  1);
    resetN = 1'b1;
    step();
    check("first_outValid", outValid, 1);
    check("first_outData",  outData,  69'h0ABC);
    check("first_outCtrl",  outCtrl,  2'b10);
    inValid = 1'b0;
    step();
    check("first_drained", outValid, 0);

    // Streaming 1..8 at full rate.
    inValid = 1'b1; inCtrl = 2'b01; inData = 69'd1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("stream_valid",   outValid, 1);
      check("stream_data",    outData,  DW'(i));
      check("stream_inReady", inReady,  1);
      if (i == 8) inValid = 1'b0;
      else        inData  = DW'(i + 1);
    end
    step();
    check("stream_drained", outValid, 0);

    // Back-pressure: A, B accepted, C held upstream.
    outReady = 1'b0; inValid = 1'b1; inCtrl = 2'b01; inData = 69'hA;
    step();
    check("bp_A_data",    outData, 69'hA);
    check("bp_A_inReady", inReady, 1);
    inData = 69'hB;
    step();
    check("bp_full_data",    outData, 69'hA);
    check("bp_full_inReady", inReady, 0);
    inData = 69'hC;
    step();
    check("bp_hold_valid",   outValid, 1);
    check("bp_hold_data",    outData,  69'hA);
    check("bp_hold_ctrl",    outCtrl,  2'b01);
    check("bp_hold_inReady", inReady,  0);
    outReady = 1'b1;
    step();
    check("bp_B_data",    outData, 69'hB);
    check("bp_B_inReady", inReady, 1);
    step();
    check("bp_C_data",  outData,  69'hC);
    check("bp_C_valid", outValid, 1);
    inValid = 1'b0;
    step();
    check("bp_drained", outValid, 0);

    // Flush a FULL stage while C is offered.
    outReady = 1'b0; inValid = 1'b1; inCtrl = 2'b11; inData = 69'hA;
    step();
    inData = 69'hB;
    step();
    check("fl_pre_inReady", inReady, 0);
    inData = 69'hC; flush = 1'b1;
    step();
    check("fl_outValid", outValid, 0);
    check("fl_outCtrl",  outCtrl,  0);
    check("fl_inReady",  inReady,  1);
    flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    step();
    check("fl_no_C", outValid, 0);

    // Bubble counting from a fresh reset.
    outReady = 1'b0; resetN = 1'b0;
    #1;
    check("bub_reset", bubbleCount, 0);
    @(negedge clock);
    resetN = 1'b1;
    outReady = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("bub_count",    bubbleCount, DW'(i));
      check("bub_regwrite", outCtrl[CTRL_REGWRITE], 0);
    end
    outReady = 1'b0;
    step();
    check("bub_hold", bubbleCount, 5);

    // Saturation on the 3-bit instance.
    check("sat_start", s_bubbleCount, 0);
    s_outReady = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("sat_count", s_bubbleCount, (i < 7) ? DW'(i) : DW'(7));
    end
    check("sat_outCtrl", s_outCtrl, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
